// File: rtl/cdc_pkg.sv
// Shared types and limits for the toggle-handshake CDC blocks.
package cdc_pkg;

  typedef enum logic {IDLE, WAIT_ACK} cdc_hs_state_t;

  localparam int CDC_MIN_STAGES = 2;

endpackage

// File: rtl/cdc_sync.sv
// Multi-flop level synchronizer for a single asynchronous bit.
module cdc_sync #(
  parameter int STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/cdc_hs_tx.sv
// Source-side launcher of a 2-phase req/ack toggle handshake.
// Optional ack-timeout flag enabled by defining CDC_HS_TIMEOUT_EN.
module cdc_hs_tx
  import cdc_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT_CYC = 256
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_valid,
  output logic              o_ready,
  output logic [DATA_W-1:0] o_data,
  output logic              o_req_tgl,
  input  logic              i_ack_tgl,
  output logic              o_done,
  output logic              o_timeout
);

  if (SYNC_STAGES < CDC_MIN_STAGES) begin : gen_bad_stages
    $error("cdc_hs_tx: SYNC_STAGES below minimum");
  end
  if (TIMEOUT_CYC < 2) begin : gen_bad_timeout
    $error("cdc_hs_tx: TIMEOUT_CYC below minimum");
  end

  cdc_hs_state_t     state_q, state_d;
  logic              ready_q, ready_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              req_q, req_d;
  logic              done_q, done_d;
  logic              ack_s;
  logic              accept;
  logic              ack_match;

  cdc_sync #(
    .STAGES(SYNC_STAGES)
  ) u_ack_sync (
    .clk_i (clk),
    .rst_ni(rstn),
    .d_i   (i_ack_tgl),
    .q_o   (ack_s)
  );

  assign accept    = (state_q == IDLE) && i_valid && ready_q;
  // Parities match once the destination has echoed our latest toggle.
  assign ack_match = (ack_s == req_q);

  always_comb begin
    state_d = state_q;
    ready_d = ready_q;
    data_d  = data_q;
    req_d   = req_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        ready_d = 1'b1;
        if (accept) begin
          data_d  = i_data;
          req_d   = ~req_q;
          ready_d = 1'b0;
          state_d = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        ready_d = 1'b0;
        if (ack_match) begin
          done_d  = 1'b1;
          ready_d = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      ready_q <= 1'b0;
      data_q  <= '0;
      req_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      data_q  <= data_d;
      req_q   <= req_d;
      done_q  <= done_d;
    end
  end

  assign o_ready   = ready_q;
  assign o_data    = data_q;
  assign o_req_tgl = req_q;
  assign o_done    = done_q;

`ifdef CDC_HS_TIMEOUT_EN
  localparam int CntW = $clog2(TIMEOUT_CYC) + 1;
  localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT_CYC - 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            timeout_q, timeout_d;

  // Counter saturates at CntMax; the FSM keeps waiting so a late ack still completes.
  always_comb begin
    cnt_d     = cnt_q;
    timeout_d = timeout_q;
    if (accept) begin
      cnt_d = '0;
    end else if ((state_q == WAIT_ACK) && !ack_match) begin
      if (cnt_q != CntMax) begin
        cnt_d = cnt_q + 1'b1;
      end
      if (cnt_d == CntMax) begin
        timeout_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign o_timeout = timeout_q;
`else
  assign o_timeout = 1'b0;
`endif

endmodule
